ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//   EX->MEM pipeline register directly downstream of the ID/EX register.
//   Captures ALU result, rt store data, destination reg, PC+4 and control bits
//   from execute. Presents them to the memory stage through a 2-entry skid
//   buffer with valid/ready handshakes on both sides, so a stalled data memory
//   back-pressures execute without losing a beat. Synchronous flush squashes
//   in-flight beats on branch mispredict.
// PARAMETERS
//   DATA_W  32  width of alu, rt and pc_add fields
//   RD_W    6   destination register index width
//   CTRL_W  5   control bundle {regwrite,memtoreg,memread,memwrite,branch}
// PORTS
//   clock       in   1       rising-edge clock
//   reset_n     in   1       asynchronous active-low reset
//   flush       in   1       squash all held beats (sync, see BEHAVIOUR)
//   in_valid    in   1       execute presents a beat
//   in_ready    out  1       stage can accept a beat (registered)
//   alu_in      in   DATA_W  ALU result
//   rt_in       in   DATA_W  store data
//   rd_in       in   RD_W    destination register
//   pc_add_in   in   DATA_W  PC+4 / branch target
//   ctrl_in     in   CTRL_W  control bundle
//   out_valid   out  1       beat available to memory stage
//   out_ready   in   1       memory stage consumes beat
//   alu_out, rt_out, pc_add_out  out DATA_W  head-beat fields
//   rd_out      out  RD_W    head-beat destination
//   ctrl_out    out  CTRL_W  head-beat control; forced 0 when out_valid=0
// BEHAVIOUR
//   - Transfer in: in_valid & in_ready at clock edge. Transfer out: out_valid & out_ready.
//   - States: EMPTY (0 beats), ONE (main reg valid), FULL (main + skid valid).
//     EMPTY: in -> ONE.
//     ONE:   in&~out -> FULL (beat to skid); out&~in -> EMPTY; in&out -> ONE (main reloads).
//     FULL:  out -> ONE (skid moves to main); in ignored (in_ready=0).
//   - in_ready = (state != FULL), registered; deasserts the cycle after entering FULL.
//   - Latency: beat accepted in EMPTY appears on outputs next cycle. Order strictly FIFO.
//   - Outputs always driven from main reg; skid never visible directly.
//   - flush=1 at an edge: state -> EMPTY, out_valid 0, in_ready 1; any beat
//     transferred in that same edge is discarded. Flush beats out_ready.
//     Data regs may retain stale values; ctrl_out is gated to 0.
//   - Simultaneous in & out in ONE: new beat replaces consumed one, no bubble.
//   - Reset (any time, incl. mid-transfer): state EMPTY, out_valid 0, in_ready 1,
//     all data/ctrl outputs 0. First accept possible on the first edge after release.
//   - No arithmetic; fields pass through unmodified at declared widths.
// CONFIGURATION
//   EX_MEM_STALL_CNT_EN defined: adds output stall_cnt [15:0]; increments each
//     cycle in_valid=1 & in_ready=0; saturates at 16'hFFFF; cleared by reset only
//     (not flush). Undefined: port and counter absent; all else identical.
// TESTING
//   1 Reset: reset_n=0 mid-run -> out_valid=0, in_ready=1, alu_out=0, ctrl_out=0 immediately.
//   2 Pass-through: out_ready=1, beat alu=4,rt=5,rd=3,pc=8,ctrl=5'b10000 -> same on outputs
//     next cycle, out_valid=1; back-to-back beats 1..10 emerge in order, no bubbles.
//   3 Back-pressure: out_ready=0, send alu=6 then alu=7 -> FULL, in_ready=0; third beat
//     alu=9 held by source; out_ready=1 -> 6,7,9 emerge in order, none lost or duplicated.
//   4 Flush: FULL with 6,7; assert flush with in_valid alu=9 -> next cycle out_valid=0,
//     ctrl_out=0, in_ready=1; beat 9 never appears.
//   5 Simultaneous in/out in ONE: alu=1 held, in alu=2 with out_ready=1 -> 1 consumed,
//     alu_out=2 next cycle, state ONE, in_ready stays 1.
//   6 EX_MEM_STALL_CNT_EN: hold in_valid=1 for 5 cycles while FULL -> stall_cnt=5;
//     flush leaves 5; reset clears to 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer and valid/ready on both sides.
// Optional stall counter output enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 6,
    parameter int CTRL_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] rt_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [DATA_W-1:0] pc_add_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] rt_out,
    output logic [DATA_W-1:0] pc_add_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [CTRL_W-1:0] ctrl_out
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rt;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] pc_add;
        logic [CTRL_W-1:0] ctrl;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;
    beat_t  main_q;
    beat_t  skid_q;
    beat_t  in_beat;
    logic   in_fire;
    logic   out_fire;
    logic   load_main;
    logic   main_from_skid;
    logic   load_skid;

    assign in_beat = '{
        alu:    alu_in,
        rt:     rt_in,
        rd:     rd_in,
        pc_add: pc_add_in,
        ctrl:   ctrl_in
    };

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_n        = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_n   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_n   = FULL;
                    load_skid = 1'b1;
                end else if (!in_fire && out_fire) begin
                    state_n = EMPTY;
                end else if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_n        = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
        // Flush wins over any transfer on the same edge; stale data is harmless.
        if (flush) begin
            state_n   = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_n;
            in_ready <= (state_n != FULL);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_beat;
            end
            if (load_skid) begin
                skid_q <= in_beat;
            end
        end
    end

    assign alu_out    = main_q.alu;
    assign rt_out     = main_q.rt;
    assign rd_out     = main_q.rd;
    assign pc_add_out = main_q.pc_add;
    assign ctrl_out   = out_valid ? main_q.ctrl : '0;

`ifdef EX_MEM_STALL_CNT_EN
    // Counts source-side stall cycles; survives flush, only reset clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: FIFO scoreboard plus directed handshake checks.
// Define EX_MEM_STALL_CNT_EN to also exercise the stall counter.
module tb_ex_mem_stage;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_in;
    logic [31:0] rt_in;
    logic [5:0]  rd_in;
    logic [31:0] pc_add_in;
    logic [4:0]  ctrl_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic [31:0] rt_out;
    logic [31:0] pc_add_out;
    logic [5:0]  rd_out;
    logic [4:0]  ctrl_out;
`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rt;
        logic [5:0]  rd;
        logic [31:0] pc;
        logic [4:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    ex_mem_stage dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_in     (alu_in),
        .rt_in      (rt_in),
        .rd_in      (rd_in),
        .pc_add_in  (pc_add_in),
        .ctrl_in    (ctrl_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .rt_out     (rt_out),
        .pc_add_out (pc_add_out),
        .rd_out     (rd_out),
        .ctrl_out   (ctrl_out)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [4:0] c);
        in_valid  = v;
        alu_in    = a;
        rt_in     = a + 32'd100;
        rd_in     = a[5:0] ^ 6'h2a;
        pc_add_in = a << 2;
        ctrl_in   = c;
    endtask

    // Inputs change at posedge+1, so the negedge sees what the next edge transfers.
    always @(negedge clock) begin
        if (!reset_n || flush) begin
            sb.delete();
        end else begin
            if (!out_valid) begin
                check("ctrl_gate", {27'd0, ctrl_out}, 32'd0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("extra_beat", alu_out, 32'hdead_beef);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_alu", alu_out, e.alu);
                    check("sb_rt", rt_out, e.rt);
                    check("sb_rd", {26'd0, rd_out}, {26'd0, e.rd});
                    check("sb_pc", pc_add_out, e.pc);
                    check("sb_ctrl", {27'd0, ctrl_out}, {27'd0, e.ctrl});
                end
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.alu  = alu_in;
                n.rt   = rt_in;
                n.rd   = rd_in;
                n.pc   = pc_add_in;
                n.ctrl = ctrl_in;
                sb.push_back(n);
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 5'd0);
        repeat (3) step();
        check("rst_ovalid", {31'd0, out_valid}, 32'd0);
        check("rst_iready", {31'd0, in_ready}, 32'd1);
        check("rst_alu", alu_out, 32'd0);
        reset_n = 1'b1;

        // Single beat pass-through with explicit field values.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_in    = 32'd4;
        rt_in     = 32'd5;
        rd_in     = 6'd3;
        pc_add_in = 32'd8;
        ctrl_in   = 5'b10000;
        step();
        drive(1'b0, 32'd0, 5'd0);
        check("pt_valid", {31'd0, out_valid}, 32'd1);
        check("pt_alu", alu_out, 32'd4);
        check("pt_rt", rt_out, 32'd5);
        check("pt_rd", {26'd0, rd_out}, 32'd3);
        check("pt_pc", pc_add_out, 32'd8);
        check("pt_ctrl", {27'd0, ctrl_out}, 32'h10);
        step();
        check("pt_drain", {31'd0, out_valid}, 32'd0);

        // Back-to-back 1..10, no bubbles.
        drive(1'b1, 32'd1, 5'd1);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("b2b_valid", {31'd0, out_valid}, 32'd1);
            check("b2b_alu", alu_out, k);
            check("b2b_iready", {31'd0, in_ready}, 32'd1);
            if (k < 10) drive(1'b1, k + 1, 5'(k + 1));
            else drive(1'b0, 32'd0, 5'd0);
        end
        step();
        check("b2b_drain", {31'd0, out_valid}, 32'd0);

        // Back-pressure: 6, 7 fill both entries, 9 waits at the source.
        out_ready = 1'b0;
        drive(1'b1, 32'd6, 5'b01000);
        step();
        check("bp_one_alu", alu_out, 32'd6);
        check("bp_one_rdy", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'd7, 5'b00100);
        step();
        check("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'd9, 5'b00010);
        repeat (2) step();
        check("bp_hold_alu", alu_out, 32'd6);
        check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_skid_alu", alu_out, 32'd7);
        check("bp_skid_rdy", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_last_alu", alu_out, 32'd9);
        drive(1'b0, 32'd0, 5'd0);
        step();
        check("bp_drain", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset from FULL, observed before any clock edge.
        out_ready = 1'b0;
        drive(1'b1, 32'd6, 5'b11111);
        step();
        drive(1'b1, 32'd7, 5'b11111);
        step();
        drive(1'b0, 32'd0, 5'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ovalid", {31'd0, out_valid}, 32'd0);
        check("arst_iready", {31'd0, in_ready}, 32'd1);
        check("arst_alu", alu_out, 32'd0);
        check("arst_ctrl", {27'd0, ctrl_out}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("arst_after", {31'd0, out_valid}, 32'd0);

`ifdef EX_MEM_STALL_CNT_EN
        drive(1'b1, 32'd6, 5'b01000);
        step();
        drive(1'b1, 32'd7, 5'b00100);
        step();
        drive(1'b1, 32'd9, 5'b00010);
        repeat (5) step();
        check("cnt_five", {16'd0, stall_cnt}, 32'd5);
        drive(1'b0, 32'd0, 5'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("cnt_flush", {16'd0, stall_cnt}, 32'd5);
        check("cnt_fl_valid", {31'd0, out_valid}, 32'd0);
`endif

        // Flush from FULL with a beat offered on the same edge.
        out_ready = 1'b0;
        drive(1'b1, 32'd6, 5'b01000);
        step();
        drive(1'b1, 32'd7, 5'b00100);
        step();
        drive(1'b1, 32'd9, 5'b00010);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0);
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ctrl", {27'd0, ctrl_out}, 32'd0);
        check("fl_iready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) step();
        check("fl_no9", {31'd0, out_valid}, 32'd0);

        // Flush in ONE while a beat is presented: the beat is dropped.
        out_ready = 1'b0;
        drive(1'b1, 32'd20, 5'b00001);
        step();
        drive(1'b1, 32'd21, 5'b00001);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0);
        check("fl1_valid", {31'd0, out_valid}, 32'd0);
        check("fl1_iready", {31'd0, in_ready}, 32'd1);

        // Simultaneous in/out while ONE.
        drive(1'b1, 32'd1, 5'b10100);
        step();
        check("sim_one_alu", alu_out, 32'd1);
        drive(1'b1, 32'd2, 5'b10010);
        out_ready = 1'b1;
        step();
        drive(1'b0, 32'd0, 5'd0);
        check("sim_alu", alu_out, 32'd2);
        check("sim_valid", {31'd0, out_valid}, 32'd1);
        check("sim_iready", {31'd0, in_ready}, 32'd1);
        step();
        check("sim_drain", {31'd0, out_valid}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);

`ifdef EX_MEM_STALL_CNT_EN
        reset_n = 1'b0;
        #1;
        check("cnt_reset", {16'd0, stall_cnt}, 32'd0);
        step();
        reset_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
